branch_predictor: RTL and testbench



---
 rtl/branch_predictor_pkg.sv | 8 +
 rtl/branch_predictor_if.sv | 31 +++
 rtl/branch_predictor_sat_counter2.sv | 27 ++
 rtl/branch_predictor.sv | 76 +++++++
 tb/tb_branch_predictor.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and default widths for the gshare branch predictor.
package branch_predictor_pkg;
    localparam int BP_PATTERN_WIDTH  = 10;
    localparam int BP_INST_MEM_WIDTH = 15;

    typedef logic [1:0] sat2_t;
    localparam sat2_t PHT_INIT = 2'b01;  // weakly not-taken
endpackage

// File: rtl/branch_predictor_if.sv
// Issue/commit/statistics bundle between the branch unit and the predictor.
interface branch_predictor_if
    import branch_predictor_pkg::*;
#(
    parameter int PATTERN_WIDTH  = BP_PATTERN_WIDTH,
    parameter int INST_MEM_WIDTH = BP_INST_MEM_WIDTH
);
    logic                      predict_valid;
    logic [INST_MEM_WIDTH-1:0] pc;
    logic [INST_MEM_WIDTH-1:0] target;
    logic                      prediction;
    logic [PATTERN_WIDTH-1:0]  pattern_out;
    logic [INST_MEM_WIDTH-1:0] addr_on_failure;
    logic                      commit_valid;
    logic [PATTERN_WIDTH-1:0]  commit_pattern;
    logic                      commit_prediction;
    logic                      commit_failure;
    logic [31:0]               stat_commits;
    logic [31:0]               stat_failures;

    modport master (
        output predict_valid, pc, target, commit_valid, commit_pattern,
               commit_prediction, commit_failure,
        input  prediction, pattern_out, addr_on_failure, stat_commits, stat_failures
    );
    modport slave (
        input  predict_valid, pc, target, commit_valid, commit_pattern,
               commit_prediction, commit_failure,
        output prediction, pattern_out, addr_on_failure, stat_commits, stat_failures
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// One PHT entry: 2-bit up/down counter saturating at 0 and 3.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  logic  up,
    output sat2_t cnt
);
    sat2_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (up && cnt_q != 2'b11)       cnt_d = cnt_q + 2'b01;
            else if (!up && cnt_q != 2'b00) cnt_d = cnt_q - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= PHT_INIT;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/branch_predictor.sv
// Gshare predictor: combinational lookup at issue, PHT/GHR training and
// history repair at commit, saturating commit/failure statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int PATTERN_WIDTH  = BP_PATTERN_WIDTH,
    parameter int INST_MEM_WIDTH = BP_INST_MEM_WIDTH
) (
    input logic               clk,
    input logic               rst_n,
    branch_predictor_if.slave bp
);
    localparam int PHT_DEPTH = 1 << PATTERN_WIDTH;

    sat2_t [PHT_DEPTH-1:0]     pht;
    logic [PATTERN_WIDTH-1:0]  idx;
    logic                      pred;
    logic                      taken;
    logic [PATTERN_WIDTH-1:0]  spec_ghr_q, spec_ghr_d;
    logic [PATTERN_WIDTH-1:0]  arch_ghr_q, arch_ghr_d;
    logic [31:0]               stat_commits_q, stat_commits_d;
    logic [31:0]               stat_failures_q, stat_failures_d;

    assign taken = bp.commit_prediction ^ bp.commit_failure;

    for (genvar g = 0; g < PHT_DEPTH; g++) begin : g_pht
        sat_counter2 u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bp.commit_valid && bp.commit_pattern == PATTERN_WIDTH'(g)),
            .up    (taken),
            .cnt   (pht[g])
        );
    end

    // Lookup reads the registered PHT, so a same-cycle commit is not bypassed.
    assign idx                = bp.pc[PATTERN_WIDTH-1:0] ^ spec_ghr_q;
    assign pred               = pht[idx][1];
    assign bp.prediction      = pred;
    assign bp.pattern_out     = idx;
    assign bp.addr_on_failure = pred ? bp.pc + INST_MEM_WIDTH'(1) : bp.target;
    assign bp.stat_commits    = stat_commits_q;
    assign bp.stat_failures   = stat_failures_q;

    always_comb begin
        spec_ghr_d      = spec_ghr_q;
        arch_ghr_d      = arch_ghr_q;
        stat_commits_d  = stat_commits_q;
        stat_failures_d = stat_failures_q;
        if (bp.commit_valid) begin
            arch_ghr_d = {arch_ghr_q[PATTERN_WIDTH-2:0], taken};
            if (stat_commits_q != '1) stat_commits_d = stat_commits_q + 32'd1;
            if (bp.commit_failure && stat_failures_q != '1)
                stat_failures_d = stat_failures_q + 32'd1;
        end
        // A mispredict flushes the issuing path, so its shift is dropped.
        if (bp.commit_valid && bp.commit_failure)
            spec_ghr_d = {arch_ghr_q[PATTERN_WIDTH-2:0], taken};
        else if (bp.predict_valid)
            spec_ghr_d = {spec_ghr_q[PATTERN_WIDTH-2:0], pred};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_ghr_q      <= '0;
            arch_ghr_q      <= '0;
            stat_commits_q  <= '0;
            stat_failures_q <= '0;
        end else begin
            spec_ghr_q      <= spec_ghr_d;
            arch_ghr_q      <= arch_ghr_d;
            stat_commits_q  <= stat_commits_d;
            stat_failures_q <= stat_failures_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: reference model feeds a scoreboard of expected lookups.
module tb_branch_predictor;
    localparam int PW = 10;
    localparam int IW = 15;

    typedef struct {
        logic          pred;
        logic [PW-1:0] pat;
        logic [IW-1:0] aof;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    exp_t          sb[$];
    exp_t          e;
    logic [1:0]    m_pht [0:(1<<PW)-1];
    logic [PW-1:0] m_spec, m_arch;
    logic [31:0]   m_commits, m_fails;

    branch_predictor_if #(.PATTERN_WIDTH(PW), .INST_MEM_WIDTH(IW)) bif ();

    branch_predictor #(.PATTERN_WIDTH(PW), .INST_MEM_WIDTH(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < (1 << PW); i++) m_pht[i] = 2'b01;
        m_spec = '0; m_arch = '0; m_commits = '0; m_fails = '0;
    endtask

    // Drive one cycle of inputs and push the model's expected lookup.
    task automatic drive(input logic pv, input logic [IW-1:0] p, input logic [IW-1:0] t,
                         input logic cv, input logic [PW-1:0] cp, input logic cpr,
                         input logic cf);
        exp_t          x;
        logic [PW-1:0] ix;
        bif.predict_valid = pv; bif.pc = p; bif.target = t;
        bif.commit_valid = cv; bif.commit_pattern = cp;
        bif.commit_prediction = cpr; bif.commit_failure = cf;
        ix    = p[PW-1:0] ^ m_spec;
        x.pred = m_pht[ix][1];
        x.pat  = ix;
        x.aof  = x.pred ? p + 15'd1 : t;
        sb.push_back(x);
    endtask

    // Advance one clock and update the model with the inputs seen at the edge.
    task automatic tick();
        logic          pr, tk;
        logic [PW-1:0] ix;
        @(posedge clk);
        ix = bif.pc[PW-1:0] ^ m_spec;
        pr = m_pht[ix][1];
        tk = bif.commit_prediction ^ bif.commit_failure;
        if (bif.commit_valid && bif.commit_failure) m_spec = {m_arch[PW-2:0], tk};
        else if (bif.predict_valid)                 m_spec = {m_spec[PW-2:0], pr};
        if (bif.commit_valid) begin
            if (tk && m_pht[bif.commit_pattern] != 2'b11)
                m_pht[bif.commit_pattern] = m_pht[bif.commit_pattern] + 2'd1;
            else if (!tk && m_pht[bif.commit_pattern] != 2'b00)
                m_pht[bif.commit_pattern] = m_pht[bif.commit_pattern] - 2'd1;
            m_arch = {m_arch[PW-2:0], tk};
            if (m_commits != '1) m_commits++;
            if (bif.commit_failure && m_fails != '1) m_fails++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++;
        if (bif.stat_commits !== 32'd0 || bif.stat_failures !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_stats: got %h/%h expected 0/0", bif.stat_commits, bif.stat_failures);
        end
        rst_n = 1'b1;
        drive(1, 15'd5, 15'd40, 0, '0, 0, 0);
        #1; e = sb.pop_front(); n_checks++;
        if ({bif.prediction, bif.pattern_out, bif.addr_on_failure} !== {1'b0, 10'd5, 15'd40}
            || {e.pred, e.pat, e.aof} !== {1'b0, 10'd5, 15'd40}) begin
            n_errors++;
            $display("FAIL reset_lookup: got %b/%0d/%0d expected 0/5/40",
                     bif.prediction, bif.pattern_out, bif.addr_on_failure);
        end
        tick();
        drive(0, 15'd0, 15'd0, 0, '0, 0, 0);
        #1; e = sb.pop_front(); n_checks++;
        if (bif.pattern_out !== 10'd0) begin
            n_errors++;
            $display("FAIL reset_spec_ghr: got %0d expected 0", bif.pattern_out);
        end
        tick();
    endtask

    task automatic test_train();
        drive(0, 15'd0, 15'd0, 1, 10'd5, 0, 1);
        #1; e = sb.pop_front(); n_checks++;
        if ({bif.prediction, bif.pattern_out, bif.addr_on_failure} !== {e.pred, e.pat, e.aof}) begin
            n_errors++;
            $display("FAIL train_lookup0: got %b/%0d expected %b/%0d", bif.prediction, bif.pattern_out, e.pred, e.pat);
        end
        tick();
        drive(0, 15'd0, 15'd0, 1, 10'd5, 1, 0);
        #1; e = sb.pop_front(); tick();
        drive(1, 15'd4, 15'd100, 0, '0, 0, 0);
        #1; e = sb.pop_front(); n_checks++;
        if ({bif.prediction, bif.pattern_out, bif.addr_on_failure} !== {1'b1, 10'd5, 15'd5}
            || {e.pred, e.pat, e.aof} !== {1'b1, 10'd5, 15'd5}) begin
            n_errors++;
            $display("FAIL train_lookup: got %b/%0d/%0d expected 1/5/5",
                     bif.prediction, bif.pattern_out, bif.addr_on_failure);
        end
        n_checks++;
        if (bif.stat_commits !== 32'd2 || bif.stat_failures !== 32'd1) begin
            n_errors++;
            $display("FAIL train_stats: got %0d/%0d expected 2/1", bif.stat_commits, bif.stat_failures);
        end
        tick();
    endtask

    task automatic test_recover();
        logic [IW-1:0] p;
        for (int i = 0; i < 4; i++) begin
            p = 15'd5 ^ {5'd0, m_spec};
            drive(1, p, 15'd200, 0, '0, 0, 0);
            #1; e = sb.pop_front(); n_checks++;
            if ({bif.prediction, bif.pattern_out, bif.addr_on_failure} !== {e.pred, e.pat, e.aof}
                || bif.prediction !== 1'b1) begin
                n_errors++;
                $display("FAIL recover_issue%0d: got %b/%0d/%0d expected 1/%0d/%0d", i,
                         bif.prediction, bif.pattern_out, bif.addr_on_failure, e.pat, e.aof);
            end
            tick();
        end
        drive(1, 15'd5 ^ {5'd0, m_spec}, 15'd200, 1, 10'd9, 1, 1);
        #1; e = sb.pop_front(); tick();
        drive(0, 15'd0, 15'd0, 0, '0, 0, 0);
        #1; e = sb.pop_front(); n_checks++;
        if (bif.pattern_out !== 10'b0000000110 || e.pat !== 10'b0000000110) begin
            n_errors++;
            $display("FAIL recover_spec_ghr: got %b expected 0000000110", bif.pattern_out);
        end
        tick();
    endtask

    task automatic test_same_index();
        drive(0, 15'd1, 15'd77, 1, 10'd7, 1, 0);
        #1; e = sb.pop_front(); n_checks++;
        if ({bif.prediction, bif.pattern_out, bif.addr_on_failure} !== {1'b0, 10'd7, 15'd77}
            || e.pred !== 1'b0) begin
            n_errors++;
            $display("FAIL same_idx_old: got %b/%0d/%0d expected 0/7/77",
                     bif.prediction, bif.pattern_out, bif.addr_on_failure);
        end
        tick();
        drive(0, 15'd1, 15'd77, 0, '0, 0, 0);
        #1; e = sb.pop_front(); n_checks++;
        if ({bif.prediction, bif.pattern_out, bif.addr_on_failure} !== {1'b1, 10'd7, 15'd2}
            || e.pred !== 1'b1) begin
            n_errors++;
            $display("FAIL same_idx_new: got %b/%0d/%0d expected 1/7/2",
                     bif.prediction, bif.pattern_out, bif.addr_on_failure);
        end
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 7; i++) begin
            drive(0, 15'd5, 15'd33, 1, 10'd3, (i >= 5), 0);
            #1; e = sb.pop_front(); n_checks++;
            if ({bif.prediction, bif.pattern_out, bif.addr_on_failure} !== {e.pred, e.pat, e.aof}
                || bif.prediction !== 1'b0) begin
                n_errors++;
                $display("FAIL sat_pht_step%0d: got %b/%0d expected 0/%0d", i,
                         bif.prediction, bif.pattern_out, e.pat);
            end
            tick();
        end
        drive(0, 15'd5, 15'd33, 0, '0, 0, 0);
        #1; e = sb.pop_front(); n_checks++;
        if (bif.prediction !== 1'b1 || e.pred !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_pht_recover: got %b expected 1", bif.prediction);
        end
        n_checks++;
        if (bif.stat_commits !== m_commits || bif.stat_failures !== m_fails) begin
            n_errors++;
            $display("FAIL stats_model: got %0d/%0d expected %0d/%0d",
                     bif.stat_commits, bif.stat_failures, m_commits, m_fails);
        end
        // Counter preload: the next value with a failure commit must hold at all-ones.
        force dut.stat_failures_q = 32'hFFFF_FFFF;
        drive(0, 15'd5, 15'd33, 1, 10'd100, 0, 1);
        #1; e = sb.pop_front(); n_checks++;
        if (dut.stat_failures_d !== 32'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL stat_failures_sat: got %h expected ffffffff", dut.stat_failures_d);
        end
        bif.commit_valid = 1'b0;
        #1; release dut.stat_failures_q;
    endtask

    task automatic test_async_reset();
        tick();
        drive(1, 15'd5, 15'd40, 1, 10'd5, 1, 0);
        #1; e = sb.pop_front();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1; n_checks++;
        if (bif.stat_commits !== 32'd0 || bif.stat_failures !== 32'd0) begin
            n_errors++;
            $display("FAIL async_reset_stats: got %0d/%0d expected 0/0", bif.stat_commits, bif.stat_failures);
        end
        n_checks++;
        if ({bif.prediction, bif.pattern_out, bif.addr_on_failure} !== {1'b0, 10'd5, 15'd40}) begin
            n_errors++;
            $display("FAIL async_reset_lookup: got %b/%0d/%0d expected 0/5/40",
                     bif.prediction, bif.pattern_out, bif.addr_on_failure);
        end
        model_reset(); sb.delete();
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (bif.stat_commits !== 32'd0 || bif.pattern_out !== 10'd5) begin
            n_errors++;
            $display("FAIL reset_commit_dropped: got %0d/%0d expected 0/5", bif.stat_commits, bif.pattern_out);
        end
        rst_n = 1'b1;
        drive(0, 15'd5, 15'd40, 0, '0, 0, 0);
        #1; e = sb.pop_front(); n_checks++;
        if ({bif.prediction, bif.pattern_out, bif.addr_on_failure} !== {e.pred, e.pat, e.aof}) begin
            n_errors++;
            $display("FAIL post_reset_lookup: got %b/%0d/%0d expected %b/%0d/%0d",
                     bif.prediction, bif.pattern_out, bif.addr_on_failure, e.pred, e.pat, e.aof);
        end
        tick();
    endtask

    initial begin
        bif.predict_valid = 0; bif.pc = '0; bif.target = '0; bif.commit_valid = 0;
        bif.commit_pattern = '0; bif.commit_prediction = 0; bif.commit_failure = 0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_train();
        test_recover();
        test_same_index();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
